mipi_tx_lane_ctrl: RTL

- Transmit-side MIPI D-PHY lane controller in the byte-clock domain; the peer end of the MIPI receive debug path.
- Takes packet words on a valid/ready stream and sequences each lane through the D-PHY burst:
  - LP-11 stop, LP-01, LP-00
  - HS-zero, sync byte 0xB8, payload
  - HS-trail, LP-11 exit
- Drives per-lane parallel HS bytes to downstream OSERDES/OBUFDS and single-ended LP levels to the LP drivers. Serialization and pad primitives sit outside this block.

---
 rtl/mipi_tx_pkg.sv | 37 +++
 rtl/mipi_tx_lane_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mipi_tx_pkg.sv
// Shared types and constants for the MIPI D-PHY transmit lane controller.
// Holds the FSM state enum, sync byte, LP levels and timing helper functions.
package mipi_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LP01,
      ST_LP00,
      ST_HSZERO,
      ST_SYNC,
      ST_DATA,
      ST_TRAIL,
      ST_EXIT
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hB8;

   // LP levels packed as {P, N}
   localparam logic [1:0] LP11 = 2'b11;
   localparam logic [1:0] LP01 = 2'b01;
   localparam logic [1:0] LP00 = 2'b00;

   // Trail drives the inverse of the final HS bit on the line.
   function automatic logic [7:0] trail_byte(input logic [7:0] last);
      return last[7] ? 8'h00 : 8'hFF;
   endfunction

   // Timing parameters of zero behave as one cycle.
   function automatic int eff_cycles(input int t);
      return (t < 1) ? 1 : t;
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mipi_tx_lane_ctrl.sv
// MIPI D-PHY transmit lane controller (byte-clock domain): sequences LP-11,
// LP-01, LP-00, HS-zero, sync, payload, trail and exit on all lanes in lockstep.
// Ports: clk, rst_n (async, active low); s_data/s_valid/s_last/s_ready word
// stream; hs_data/hs_en to the serializers; lp_p/lp_n to the LP drivers;
// busy (not IDLE); underrun (sticky until reset).
module mipi_tx_lane_ctrl
   import mipi_tx_pkg::*;
#(
   parameter int MIPI_LANES   = 1,
   parameter int T_LPX        = 4,
   parameter int T_HS_PREPARE = 3,
   parameter int T_HS_ZERO    = 8,
   parameter int T_HS_TRAIL   = 5,
   parameter int T_HS_EXIT    = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [8*MIPI_LANES-1:0]   s_data,
   input  logic                      s_valid,
   input  logic                      s_last,
   output logic                      s_ready,
   output logic [8*MIPI_LANES-1:0]   hs_data,
   output logic                      hs_en,
   output logic [MIPI_LANES-1:0]     lp_p,
   output logic [MIPI_LANES-1:0]     lp_n,
   output logic                      busy,
   output logic                      underrun
);

   if (MIPI_LANES != 1 && MIPI_LANES != 2 && MIPI_LANES != 4) begin : g_bad_lanes
      $fatal(1, "mipi_tx_lane_ctrl: MIPI_LANES must be 1, 2 or 4");
   end

   localparam int LPX  = eff_cycles(T_LPX);
   localparam int PREP = LPX + eff_cycles(T_HS_PREPARE);
   localparam int ZERO = eff_cycles(T_HS_ZERO);
   localparam int TRL  = eff_cycles(T_HS_TRAIL);
   localparam int EXT  = eff_cycles(T_HS_EXIT);
   localparam int TMAX = max_of(max_of(max_of(LPX, PREP), max_of(ZERO, TRL)), EXT);
   localparam int CW   = $clog2(TMAX) + 1;

   localparam logic [CW-1:0] LD_LPX   = CW'(LPX - 1);
   localparam logic [CW-1:0] LD_PREP  = CW'(PREP - 1);
   localparam logic [CW-1:0] LD_ZERO  = CW'(ZERO - 1);
   localparam logic [CW-1:0] LD_TRL   = CW'(TRL - 1);
   // After s_last the first TRAIL cycle still shows the final payload word,
   // so the count is one longer and that cycle is recognised by its value.
   localparam logic [CW-1:0] LD_TRL_P = CW'(TRL);
   localparam logic [CW-1:0] LD_EXT   = CW'(EXT - 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [1:0]      lp_lvl;
   logic [8*MIPI_LANES-1:0] trail_all;

   assign s_ready = (state == ST_SYNC) || (state == ST_DATA);
   assign lp_p    = {MIPI_LANES{lp_lvl[1]}};
   assign lp_n    = {MIPI_LANES{lp_lvl[0]}};

   always_comb begin
      trail_all = '0;
      for (int i = 0; i < MIPI_LANES; i++) begin
         trail_all[8*i +: 8] = trail_byte(hs_data[8*i +: 8]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         lp_lvl   <= LP11;
         hs_en    <= 1'b0;
         hs_data  <= '0;
         busy     <= 1'b0;
         underrun <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               // cnt carries the remainder of the exit time
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (s_valid) begin
                  state  <= ST_LP01;
                  cnt    <= LD_LPX;
                  lp_lvl <= LP01;
                  busy   <= 1'b1;
               end
            end
            ST_LP01: begin
               if (cnt == '0) begin
                  state  <= ST_LP00;
                  cnt    <= LD_PREP;
                  lp_lvl <= LP00;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_LP00: begin
               if (cnt == '0) begin
                  state   <= ST_HSZERO;
                  cnt     <= LD_ZERO;
                  hs_en   <= 1'b1;
                  hs_data <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_HSZERO: begin
               if (cnt == '0) begin
                  state   <= ST_SYNC;
                  hs_data <= {MIPI_LANES{SYNC_BYTE}};
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_SYNC, ST_DATA: begin
               if (s_valid) begin
                  hs_data <= s_data;
                  if (s_last) begin
                     state <= ST_TRAIL;
                     cnt   <= LD_TRL_P;
                  end else begin
                     state <= ST_DATA;
                  end
               end else begin
                  underrun <= 1'b1;
                  hs_data  <= trail_all;
                  state    <= ST_TRAIL;
                  cnt      <= LD_TRL;
               end
            end
            ST_TRAIL: begin
               if (cnt == LD_TRL_P) begin
                  hs_data <= trail_all;
               end
               if (cnt == '0) begin
                  state   <= ST_EXIT;
                  cnt     <= LD_EXT;
                  hs_en   <= 1'b0;
                  hs_data <= '0;
                  lp_lvl  <= LP11;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_EXIT: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
